// File: rtl/rcv_ctrl_pkg.sv
// Shared types and defaults for the UART receive drain controller.
// Optional error counters in rcv_drain_ctrl are enabled by RCV_ERR_CNT_EN.
package rcv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } rcv_ctrl_state_t;

    localparam int RCV_FIFO_DEPTH_DEF = 4;
    localparam int RCV_ERR_CNT_W_DEF  = 8;

endpackage

// File: rtl/rcv_fifo.sv
// Small first-word fall-through byte FIFO. DEPTH must be a power of two so
// the pointers wrap naturally. Data is zero whenever the FIFO is empty.
module rcv_fifo
    import rcv_ctrl_pkg::*;
#(
    parameter int DEPTH = RCV_FIFO_DEPTH_DEF,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? 8'h00 : mem[rd_ptr];

    // Storage array, written on an accepted push only.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rcv_drain_ctrl.sv
// Drains the UART receive block: captures each byte into a FIFO, acks it
// with a one-cycle data_read pulse, and keeps sticky framing/overrun status.
// Define RCV_ERR_CNT_EN to add saturating fe_count/ov_count outputs.
//
// Output stream handshake: out_data is meaningful while out_valid is high;
// a byte is consumed on a rising clk edge where out_valid && out_ready, and
// out_data/out_valid do not depend combinationally on out_ready.
module rcv_drain_ctrl
    import rcv_ctrl_pkg::*;
#(
    parameter int DEPTH = RCV_FIFO_DEPTH_DEF
`ifdef RCV_ERR_CNT_EN
    ,
    parameter int CNT_W = RCV_ERR_CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       rx_data,
    input  logic             data_ready,
    input  logic             framing_error,
    input  logic             overrun_error,
    output logic             data_read,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic             fe_sticky,
    output logic             ov_sticky,
    output logic [1:0]       fsm_state
`ifdef RCV_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] fe_count,
    output logic [CNT_W-1:0] ov_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    rcv_ctrl_state_t state;
    rcv_ctrl_state_t state_next;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic            fe_q;
    logic            ov_q;
    logic            fe_rise;
    logic            ov_rise;

    assign fsm_state = state;
    assign out_valid = (count != '0);
    assign pop       = !empty && out_ready;
    assign fe_rise   = framing_error && !fe_q;
    assign ov_rise   = overrun_error && !ov_q;

    rcv_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .wdata (rx_data),
        .pop   (pop),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and capture decision. A framing-error byte is acked to free
    // the receiver but never stored; a full FIFO leaves the byte in place.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (data_ready && framing_error) begin
                    state_next = ACK;
                end else if (data_ready && !full) begin
                    push       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (!data_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered ack pulse: high exactly for the cycle spent in ACK.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_read <= 1'b0;
        end else begin
            data_read <= (state_next == ACK);
        end
    end

    // Edge-detect registers and sticky flags; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            fe_sticky <= 1'b0;
            ov_sticky <= 1'b0;
        end else begin
            fe_q <= framing_error;
            ov_q <= overrun_error;
            if (fe_rise) begin
                fe_sticky <= 1'b1;
            end else if (clr_err) begin
                fe_sticky <= 1'b0;
            end
            if (ov_rise) begin
                ov_sticky <= 1'b1;
            end else if (clr_err) begin
                ov_sticky <= 1'b0;
            end
        end
    end

`ifdef RCV_ERR_CNT_EN
    // Saturating event counters; clear plus increment leaves the count at 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fe_count <= '0;
            ov_count <= '0;
        end else begin
            if (clr_err) begin
                fe_count <= fe_rise ? CNT_W'(1) : '0;
            end else if (fe_rise && (fe_count != '1)) begin
                fe_count <= fe_count + CNT_W'(1);
            end
            if (clr_err) begin
                ov_count <= ov_rise ? CNT_W'(1) : '0;
            end else if (ov_rise && (ov_count != '1)) begin
                ov_count <= ov_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rcv_drain_ctrl.sv
// Bench for rcv_drain_ctrl: directed receive-block stimulus, an expected-byte
// queue drained by a monitor on the output stream, plus direct status checks.
// Counter checks are compiled in when RCV_ERR_CNT_EN is defined.
module tb_rcv_drain_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       data_ready = 1'b0;
    logic       framing_error = 1'b0;
    logic       overrun_error = 1'b0;
    logic       data_read;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic       fe_sticky;
    logic       ov_sticky;
    logic [1:0] fsm_state;
`ifdef RCV_ERR_CNT_EN
    logic [7:0] fe_count;
    logic [7:0] ov_count;
`endif

    int total = 0;
    int bad = 0;
    int rd_pulses = 0;
    logic [7:0] exp_q[$];

    rcv_drain_ctrl #(
        .DEPTH (4)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .data_read     (data_read),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .clr_err       (clr_err),
        .fe_sticky     (fe_sticky),
        .ov_sticky     (ov_sticky),
        .fsm_state     (fsm_state)
`ifdef RCV_ERR_CNT_EN
        ,
        .fe_count      (fe_count),
        .ov_count      (ov_count)
`endif
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Count ack pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (data_read) rd_pulses++;
    end

    // Scoreboard monitor: every accepted output byte must match the queue head.
    always @(negedge clk) begin
        if (n_rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: actual=%02h required=no_pop", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL pop_data: actual=%02h required=%02h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the ack pulse, then behave like the receiver clearing its flag.
    task automatic wait_ack(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (data_read) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
        cycle();
        data_ready = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data    = b;
        data_ready = 1'b1;
        exp_q.push_back(b);
        wait_ack("ack_byte");
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
    endtask

    initial begin
        int p0;
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_read", {31'd0, data_read}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'h00);
        check("rst_fe_sticky", {31'd0, fe_sticky}, 32'd0);
        check("rst_ov_sticky", {31'd0, ov_sticky}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
`ifdef RCV_ERR_CNT_EN
        check("rst_fe_count", {24'd0, fe_count}, 32'd0);
        check("rst_ov_count", {24'd0, ov_count}, 32'd0);
`endif
        n_rst = 1'b1;
        repeat (5) cycle();
        check("idle_no_ack", rd_pulses, 32'd0);

        // Single byte
        p0 = rd_pulses;
        send_byte(8'hD5);
        repeat (3) cycle();
        check("single_one_pulse", rd_pulses - p0, 32'd1);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_data", {24'd0, out_data}, 32'hD5);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("single_drained", {31'd0, out_valid}, 32'd0);

        // Full FIFO: fifth byte waits until a slot opens
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        rx_data    = 8'h55;
        data_ready = 1'b1;
        exp_q.push_back(8'h55);
        p0 = rd_pulses;
        repeat (5) cycle();
        check("full_no_ack", rd_pulses - p0, 32'd0);
        check("full_state_idle", {30'd0, fsm_state}, 32'd0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        wait_ack("full_late_ack");
        out_ready = 1'b1;
        repeat (4) cycle();
        out_ready = 1'b0;
        check("full_drained", {31'd0, out_valid}, 32'd0);
        check("full_queue_empty", exp_q.size(), 32'd0);

        // Simultaneous push and pop at count=2
        send_byte(8'hA1);
        send_byte(8'hA2);
        rx_data    = 8'hA3;
        data_ready = 1'b1;
        out_ready  = 1'b1;
        exp_q.push_back(8'hA3);
        cycle();
        out_ready = 1'b0;
        wait_ack("pp_ack");
        check("pp_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        repeat (2) cycle();
        out_ready = 1'b0;
        check("pp_count_two", {31'd0, out_valid}, 32'd0);
        check("pp_queue_empty", exp_q.size(), 32'd0);

        // Framing error with data_ready: acked but not captured
        rx_data       = 8'hEE;
        data_ready    = 1'b1;
        framing_error = 1'b1;
        wait_ack("fe_release_ack");
        framing_error = 1'b0;
        cycle();
        check("fe_no_capture", {31'd0, out_valid}, 32'd0);
        check("fe_byte_sticky", {31'd0, fe_sticky}, 32'd1);
        do_clr();
        check("clr_fe_sticky", {31'd0, fe_sticky}, 32'd0);

        // Framing pulse
        framing_error = 1'b1;
        cycle();
        framing_error = 1'b0;
        cycle();
        check("fe_pulse_sticky", {31'd0, fe_sticky}, 32'd1);
        check("fe_pulse_ov_clear", {31'd0, ov_sticky}, 32'd0);
`ifdef RCV_ERR_CNT_EN
        check("fe_pulse_count", {24'd0, fe_count}, 32'd1);
`endif
        do_clr();
        check("fe_clr_sticky", {31'd0, fe_sticky}, 32'd0);
`ifdef RCV_ERR_CNT_EN
        check("fe_clr_count", {24'd0, fe_count}, 32'd0);
`endif
        // Held high for 3 cycles counts once
        framing_error = 1'b1;
        repeat (3) cycle();
        framing_error = 1'b0;
        cycle();
        check("fe_hold_sticky", {31'd0, fe_sticky}, 32'd1);
`ifdef RCV_ERR_CNT_EN
        check("fe_hold_count", {24'd0, fe_count}, 32'd1);
`endif
        do_clr();
        // Clear coinciding with a set event: set wins
        framing_error = 1'b1;
        clr_err       = 1'b1;
        cycle();
        framing_error = 1'b0;
        clr_err       = 1'b0;
        cycle();
        check("clr_set_sticky", {31'd0, fe_sticky}, 32'd1);
`ifdef RCV_ERR_CNT_EN
        check("clr_set_count", {24'd0, fe_count}, 32'd1);
`endif

        // Overrun saturation
        repeat (300) begin
            overrun_error = 1'b1;
            cycle();
            overrun_error = 1'b0;
            cycle();
        end
        check("ov_sticky", {31'd0, ov_sticky}, 32'd1);
`ifdef RCV_ERR_CNT_EN
        check("ov_saturated", {24'd0, ov_count}, 32'hFF);
        check("ov_fe_unchanged", {24'd0, fe_count}, 32'd1);
`endif
        do_clr();
        check("final_clr_fe", {31'd0, fe_sticky}, 32'd0);
        check("final_clr_ov", {31'd0, ov_sticky}, 32'd0);
`ifdef RCV_ERR_CNT_EN
        check("final_clr_fe_count", {24'd0, fe_count}, 32'd0);
        check("final_clr_ov_count", {24'd0, ov_count}, 32'd0);
`endif

        // Reset while in ACK
        begin
            bit seen;
            seen       = 1'b0;
            rx_data    = 8'h77;
            data_ready = 1'b1;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (data_read) seen = 1'b1;
            end
            check("rst_ack_seen", {31'd0, seen}, 32'd1);
            #2;
            n_rst = 1'b0;
            #1;
            check("rst_ack_drop", {31'd0, data_read}, 32'd0);
            check("rst_ack_empty", {31'd0, out_valid}, 32'd0);
            check("rst_ack_data", {24'd0, out_data}, 32'h00);
            data_ready = 1'b0;
            cycle();
            n_rst = 1'b1;
            repeat (2) cycle();
            check("rst_ack_idle", {30'd0, fsm_state}, 32'd0);
            check("rst_ack_still_empty", {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rcv_drain_ctrl.md
# rcv_drain_ctrl

Controller that sits directly on the outputs of the UART receive block and sequences its read handshake. It captures each completed byte, acknowledges it with a one-cycle `data_read` pulse, and buffers it in a small FIFO presented to downstream logic as a valid/ready stream. It also converts the receiver's framing and overrun indications into sticky, software-clearable status.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CNT_W`, 8: width of the error counters (only when `RCV_ERR_CNT_EN` is defined).
- `clk`  in  1  system clock; single clock domain.
- `n_rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from the receive block.
- `data_ready`  in  1  receive block holds a valid byte.
- `framing_error`  in  1  receive block framing error (bad stop bit).
- `overrun_error`  in  1  receive block overrun indication.
- `data_read`  out  1  acknowledge to the receive block; registered one-cycle pulse.
- `out_data`  out  8  head-of-FIFO byte.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `clr_err`  in  1  clears sticky flags (and counters) this cycle.
- `fe_sticky`  out  1  a framing error has occurred since the last clear.
- `ov_sticky`  out  1  an overrun has occurred since the last clear.
- `fe_count`, `ov_count`  out  `CNT_W`  saturating event counts; present only with the macro.

## Operation
- **FSM states:** IDLE, ACK, WAIT.
  - **IDLE → ACK:** when `data_ready`=1 and the FIFO is not full. `rx_data` is written to the FIFO on the same edge.
  - **ACK:** `data_read`=1 for exactly this one cycle; next state is WAIT.
  - **WAIT:** `data_read`=0. Return to IDLE when `data_ready`=0. This guards against double-capture while the receive block clears its flag.
- **FIFO full in IDLE:** no capture and no `data_read`. The byte is left in the receive block, whose overrun flag then reports any loss.
- **`framing_error`:** `data_ready` is not expected to be set alongside it, so no capture is attempted. If `data_ready`=1 while `framing_error`=1, the byte is still not captured; the FSM goes through ACK only to release the receive block.
- **FIFO:** first-word fall-through. `out_valid` = (count != 0); a pop occurs when `out_valid` && `out_ready`. A push and a pop in the same cycle are both honoured, and count is unchanged. Pointers wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits wide.
- **Sticky flags:** set on a rising edge (0→1) of `framing_error` / `overrun_error`, detected against a registered copy of each input. A `clr_err` in the same cycle as a set event: the set wins.

## Timing
- **Reset values:** `data_read`=0, `out_valid`=0, `out_data`=8'h00, `fe_sticky`=0, `ov_sticky`=0, counters 0, FSM in IDLE, FIFO empty, edge registers 0.
- **Capture latency:** `data_ready` sampled high at edge N → `data_read` high during cycle N..N+1, and `out_valid` high after edge N.
- **Minimum spacing:** 3 cycles between captures. The receiver bit period is 10 cycles, so this never limits throughput.
- **Status latency:** a flag edge sampled at edge N+1 (first high sample) → sticky set after that edge.
- **Reset mid-operation:** asserting `n_rst` while in ACK drops `data_read` immediately (asynchronously) and empties the FIFO.

## Configuration
- **`RCV_ERR_CNT_EN`** defined: `fe_count` and `ov_count` exist. Each increments on its flag's rising edge and saturates at all-ones. `clr_err` zeroes both; when a clear and an increment coincide, the counter ends at 1.
- **Undefined:** the count ports and their logic are omitted; sticky flags only.

## Structure
- **Package `rcv_ctrl_pkg`:** state enum `rcv_ctrl_state_t` {IDLE, ACK, WAIT}, `RCV_FIFO_DEPTH_DEF`=4, `RCV_ERR_CNT_W_DEF`=8.
- **Sub-module `rcv_fifo`:** parameterised by `DEPTH`, 8-bit data; push/pop/full/empty/count. The FSM and status logic stay in `rcv_drain_ctrl`.

## Test plan
- **Reset:** `n_rst` low for 2 cycles → all outputs at their reset values; `data_read` never pulses with `data_ready`=0.
- **Single byte:** `data_ready`=1 with `rx_data`=8'hD5, `out_ready`=0 → exactly one `data_read` pulse; `out_valid`=1 and `out_data`=8'hD5 one cycle later; then `out_ready`=1 for one cycle → `out_valid`=0.
- **Full FIFO:** 4 bytes 8'h11..8'h44 with `out_ready`=0, then a fifth byte → no `data_read` for the fifth byte. Pop once → the fifth byte is captured. Popping all five yields order 11, 22, 33, 44, 55.
- **Simultaneous push and pop:** count=2, a capture and a pop in the same cycle → count stays 2 and order is preserved.
- **Errors:** pulse `framing_error` → `fe_sticky`=1, and with the macro `fe_count`=1. Hold `framing_error` high for 3 cycles → still counts 1. Hold `overrun_error` high for 255+ edge events → `ov_count`=8'hFF (saturated). `clr_err` → flags and counts 0.
- **Reset during ACK:** assert `n_rst` while `data_read`=1 → `data_read`=0 at once, FIFO empty, FSM in IDLE after release.
